// File: rtl/dma_timing_ctrl.sv
// -----------------------------------------------------------------------------
// dma_timing_ctrl
// Timing/control engine for a small single-transfer DMA controller. Arbitrates
// between NUM_CH request channels, handshakes the bus with the CPU (HRQ/HLDA)
// and sequences the address/read/write strobes of one transfer per grant.
// Each channel has a word counter that counts down and flags terminal count
// (eop).
//
// Optional feature macro: ROTATING_PRIORITY_EN
//   undefined : fixed priority, channel 0 highest
//   defined   : the channel served last becomes lowest priority after each S4
//
// Ports
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_dreq, i_mask            per-channel request (level) and mask (1 = ignore)
//   i_xfer_wr                 per-channel direction, 1 = IO->memory
//   i_hlda                    hold acknowledge from the CPU
//   i_ext_eop_n               external terminate, active-low
//   i_wc_load/_chan/_value    word-count programming port
//   o_hrq, o_dack             hold request, one-hot channel acknowledge
//   o_idle_cycle/o_active_cycle  cycle-type flags
//   o_ior/o_iow/o_memr/o_memw active-low bus strobes
//   o_aen, o_adstb            address enable / address strobe
//   o_eop                     terminal count, active-low
//   o_addr_inc                one-cycle address advance pulse
//   o_wc_count                all word counters, channel c at [c*WC_W +: WC_W]
// -----------------------------------------------------------------------------
module dma_timing_ctrl #(
  parameter int  NUM_CH = 4,
  parameter int  WC_W   = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_CH-1:0]      i_dreq,
  input  logic [NUM_CH-1:0]      i_mask,
  input  logic [NUM_CH-1:0]      i_xfer_wr,
  input  logic                   i_hlda,
  input  logic                   i_ext_eop_n,
  input  logic                   i_wc_load,
  input  logic [CH_W-1:0]        i_wc_chan,
  input  logic [WC_W-1:0]        i_wc_value,
  output logic                   o_hrq,
  output logic [NUM_CH-1:0]      o_dack,
  output logic                   o_idle_cycle,
  output logic                   o_active_cycle,
  output logic                   o_ior,
  output logic                   o_iow,
  output logic                   o_memr,
  output logic                   o_memw,
  output logic                   o_aen,
  output logic                   o_adstb,
  output logic                   o_eop,
  output logic                   o_addr_inc,
  output logic [NUM_CH*WC_W-1:0] o_wc_count
);

  typedef enum logic [2:0] {
    ST_SI = 3'd0, ST_S0 = 3'd1, ST_S1 = 3'd2,
    ST_S2 = 3'd3, ST_S3 = 3'd4, ST_S4 = 3'd5
  } state_t;

  localparam logic [CH_W-1:0] CH_ZERO = {CH_W{1'b0}};
  localparam logic [CH_W-1:0] CH_ONE  = CH_W'(1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ch, w_ch, w_win, w_ptr;
  logic              w_found, r_abort, w_abort_nxt;
  logic [WC_W-1:0]   r_wc [NUM_CH];
  logic [WC_W-1:0]   w_wc_pre;
  logic [NUM_CH-1:0] w_req;

  // Registered outputs and their next values (decoded from the next state so
  // every output changes cleanly on the clock edge).
  logic              r_hrq, r_idle, r_act, r_aen, r_adstb, r_inc, r_eop;
  logic              r_ior, r_iow, r_memr, r_memw;
  logic [NUM_CH-1:0] r_dack;
  logic              w_hrq, w_idle, w_act, w_aen, w_adstb, w_inc, w_eop;
  logic              w_ior, w_iow, w_memr, w_memw;
  logic [NUM_CH-1:0] w_dack;

  // Cyclic search for the first requesting channel starting at ptr.
  function automatic logic [CH_W:0] f_pick(input logic [NUM_CH-1:0] req,
                                           input logic [CH_W-1:0]   ptr);
    logic            found;
    logic [CH_W-1:0] idx;
    int              j;
    found = 1'b0;
    idx   = {CH_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = CH_W'(j);
      end
    end
    return {found, idx};
  endfunction

`ifdef ROTATING_PRIORITY_EN
  logic [CH_W-1:0] r_rot_ptr;

  // Rotation pointer: the channel after the one just served gets top priority.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rot_ptr <= CH_ZERO;
    end else if (r_state == ST_S4) begin
      r_rot_ptr <= (r_ch == CH_LAST) ? CH_ZERO : r_ch + CH_ONE;
    end else begin
      r_rot_ptr <= r_rot_ptr;
    end
  end
  assign w_ptr = r_rot_ptr;
`else
  assign w_ptr = CH_ZERO;
`endif

  assign w_req              = i_dreq & ~i_mask;
  assign {w_found, w_win}   = f_pick(w_req, w_ptr);
  // The winner is only open to change while leaving S0; afterwards it is frozen.
  assign w_ch               = (r_state == ST_S0) ? w_win : r_ch;
  // Count value the channel will hold on the next cycle (a load wins).
  assign w_wc_pre           = (i_wc_load && (i_wc_chan == w_ch)) ? i_wc_value : r_wc[w_ch];

  // Next-state logic and next-output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_abort_nxt = r_abort;
    case (r_state)
      ST_SI: begin
        if (|w_req) w_state_nxt = ST_S0;
        else        w_state_nxt = ST_SI;
      end
      ST_S0: begin
        w_abort_nxt = 1'b0;
        if (i_hlda) w_state_nxt = w_found ? ST_S1 : ST_SI;
        else        w_state_nxt = ST_S0;
      end
      ST_S1, ST_S2, ST_S3: begin
        if (!i_hlda) begin
          w_state_nxt = ST_SI;
        end else if (!i_ext_eop_n) begin
          w_state_nxt = ST_S4;
          w_abort_nxt = 1'b1;
        end else begin
          w_state_nxt = (r_state == ST_S1) ? ST_S2 :
                        (r_state == ST_S2) ? ST_S3 : ST_S4;
        end
      end
      ST_S4:   w_state_nxt = ST_SI;
      default: w_state_nxt = ST_SI;
    endcase

    w_hrq   = (w_state_nxt != ST_SI);
    w_idle  = (w_state_nxt == ST_SI);
    w_act   = (w_state_nxt == ST_S1) || (w_state_nxt == ST_S2) ||
              (w_state_nxt == ST_S3) || (w_state_nxt == ST_S4);
    w_aen   = w_act;
    w_adstb = (w_state_nxt == ST_S1);
    for (int i = 0; i < NUM_CH; i++) begin
      w_dack[i] = w_act && (w_ch == CH_W'(i));
    end
    // Read strobe covers S2..S3, write strobe S3 only; direction picks which pair.
    if ((w_state_nxt == ST_S2) || (w_state_nxt == ST_S3)) begin
      w_ior  = !i_xfer_wr[w_ch];
      w_memr =  i_xfer_wr[w_ch];
    end else begin
      w_ior  = 1'b1;
      w_memr = 1'b1;
    end
    if (w_state_nxt == ST_S3) begin
      w_memw = !i_xfer_wr[w_ch];
      w_iow  =  i_xfer_wr[w_ch];
    end else begin
      w_memw = 1'b1;
      w_iow  = 1'b1;
    end
    w_inc = (w_state_nxt == ST_S4) && !w_abort_nxt;
    w_eop = !((w_state_nxt == ST_S4) && !w_abort_nxt && (w_wc_pre == {WC_W{1'b0}}));
  end

  // State, frozen channel, abort flag and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_SI;
      r_ch    <= CH_ZERO;
      r_abort <= 1'b0;
      r_hrq   <= 1'b0;
      r_idle  <= 1'b1;
      r_act   <= 1'b0;
      r_aen   <= 1'b0;
      r_adstb <= 1'b0;
      r_dack  <= {NUM_CH{1'b0}};
      r_ior   <= 1'b1;
      r_iow   <= 1'b1;
      r_memr  <= 1'b1;
      r_memw  <= 1'b1;
      r_inc   <= 1'b0;
      r_eop   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch;
      r_abort <= w_abort_nxt;
      r_hrq   <= w_hrq;
      r_idle  <= w_idle;
      r_act   <= w_act;
      r_aen   <= w_aen;
      r_adstb <= w_adstb;
      r_dack  <= w_dack;
      r_ior   <= w_ior;
      r_iow   <= w_iow;
      r_memr  <= w_memr;
      r_memw  <= w_memw;
      r_inc   <= w_inc;
      r_eop   <= w_eop;
    end
  end

  // Word counters: programming load has precedence over the S4 decrement.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NUM_CH; i++) r_wc[i] <= {WC_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_wc_load && (i_wc_chan == CH_W'(i))) begin
          r_wc[i] <= i_wc_value;
        end else if ((r_state == ST_S4) && !r_abort && (r_ch == CH_W'(i))) begin
          r_wc[i] <= r_wc[i] - WC_ONE;
        end else begin
          r_wc[i] <= r_wc[i];
        end
      end
    end
  end

  // Flatten the counter array onto the readback port.
  always_comb begin
    o_wc_count = {(NUM_CH*WC_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) o_wc_count[i*WC_W +: WC_W] = r_wc[i];
  end

  assign o_hrq          = r_hrq;
  assign o_dack         = r_dack;
  assign o_idle_cycle   = r_idle;
  assign o_active_cycle = r_act;
  assign o_aen          = r_aen;
  assign o_adstb        = r_adstb;
  assign o_ior          = r_ior;
  assign o_iow          = r_iow;
  assign o_memr         = r_memr;
  assign o_memw         = r_memw;
  assign o_addr_inc     = r_inc;
  assign o_eop          = r_eop;

endmodule

// File: doc/dma_timing_ctrl.md
DMA_TIMING_CTRL -- requirements
Module: dma_timing_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, number of DMA request channels.
REQ-002 Parameter WC_W, default 16, word-count register width.
REQ-003 CLK  in  1  single clock; all state updates on rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 DREQ  in  NUM_CH  per-channel transfer request, active-high, level.
REQ-006 MASK  in  NUM_CH  per-channel mask; 1 means the request is ignored.
REQ-007 XFER_WR  in  NUM_CH  per-channel direction; 1 = IO-to-memory (ior+memw), 0 = memory-to-IO (memr+iow).
REQ-008 HLDA  in  1  hold acknowledge from the CPU.
REQ-009 EXT_EOP_N  in  1  external terminate, active-low.
REQ-010 WC_LOAD / WC_CHAN / WC_VALUE  in  1 / log2(NUM_CH) / WC_W  word-count programming strobe, target channel and value.
REQ-011 HRQ  out  1  hold request to the CPU.
REQ-012 DACK  out  NUM_CH  one-hot channel acknowledge, active-high.
REQ-013 IDLE_CYCLE / ACTIVE_CYCLE  out  1 each  cycle-type flags consumed by the datapath.
REQ-014 ior / iow / memr / memw  out  1 each  active-low strobes.
REQ-015 aen / adstb  out  1 each  address enable and address strobe, active-high.
REQ-016 eop  out  1  terminal-count end of process, active-low.
REQ-017 ADDR_INC  out  1  one-cycle pulse telling the datapath to advance the address.

Function
REQ-018 FSM states: SI, S0, S1, S2, S3, S4; exactly one state is active at any time.
REQ-019 In SI, an unmasked asserted DREQ moves the FSM to S0 with HRQ=1 on the next edge; IDLE_CYCLE=1 only in SI.
REQ-020 In S0, HRQ stays 1 until HLDA=1; the FSM then latches the winning channel and goes to S1.
REQ-021 Fixed priority selects the channel: channel 0 is highest; the winner is frozen from S0 exit until return to SI.
REQ-022 S1: aen=1, adstb=1, DACK[ch]=1, ACTIVE_CYCLE=1; next state S2.
REQ-023 S2: adstb=0; ior=0 if XFER_WR[ch]=1, otherwise memr=0; next state S3.
REQ-024 S3: the read strobe stays 0; memw=0 if XFER_WR[ch]=1, otherwise iow=0; next state S4.
REQ-025 S4: all strobes return to 1, ADDR_INC pulses, and the word count of ch decrements by 1, wrapping 0 to all-ones.
REQ-026 eop is driven to 0 in S4 when the pre-decrement count equals 0; eop is 1 in every other state.
REQ-027 From S4, the FSM goes to SI with HRQ=0 and DACK=0 (single-transfer mode: one transfer per grant).
REQ-028 EXT_EOP_N=0 sampled in S1-S3 forces S4 as the next state; the count is not decremented and eop stays 1.
REQ-029 HLDA=0 in S1-S3 forces SI on the next edge, with all strobes inactive and no decrement.
REQ-030 DREQ deasserted after S0 has no effect; the current transfer completes.
REQ-031 WC_LOAD takes effect on the next edge; if it targets ch in S4, the loaded value wins over the decrement.
REQ-032 A masked channel is never granted, even if DREQ is held.

Reset
REQ-033 While RESET_N=0, the FSM is in SI and outputs are: HRQ=0, DACK=0, aen=0, adstb=0, ADDR_INC=0, ACTIVE_CYCLE=0, IDLE_CYCLE=1, ior=iow=memr=memw=eop=1.
REQ-034 Reset clears all word counts to 0 and clears the rotation pointer.
REQ-035 Reset asserted mid-transfer forces the REQ-033 values immediately, without waiting for a clock edge.

Configuration
REQ-036 With macro ROTATING_PRIORITY_EN defined, the channel served last becomes lowest priority after each S4; without it, fixed priority per REQ-021 applies.

Verification
REQ-037 Single request: DREQ=4'b0001, XFER_WR=0, HLDA=1 one cycle after HRQ -> S1..S4 sequence, memr=0 in S2-S3, iow=0 in S3, one ADDR_INC pulse, DACK=4'b0001 for 4 cycles.
REQ-038 Terminal count: WC_VALUE=0 loaded on channel 2, then one transfer -> eop=0 in S4 only, and the count reads 16'hFFFF afterwards.
REQ-039 Priority: DREQ=4'b1010 held through three grants -> fixed priority grants 1,1,1; with ROTATING_PRIORITY_EN the grants are 1,3,1.
REQ-040 Abort: EXT_EOP_N=0 in S2 -> next state S4, count unchanged, eop=1; HLDA=0 in S2 -> next state SI with all strobes 1.
REQ-041 Reset: RESET_N=0 asserted in S3 -> all outputs take their REQ-033 values before the next clock edge, and the FSM restarts from SI.
REQ-042 Mask and load collision: MASK=4'b0001 with DREQ=4'b0001 -> HRQ stays 0; WC_LOAD of 5 to the active channel in S4 -> count reads 5.
